// File: rtl/uart_byte_tx.sv
// UART byte transmitter: internal baud divider, valid/ready intake, start/data/stop framing.
module uart_byte_tx #(
  parameter int unsigned CLOCK_RATE = 100_000,
  parameter int unsigned BAUD_RATE  = 9600,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  valid,
  output logic                  ready,
  output logic                  tx,
  output logic                  busy
);

  // Clock cycles per bit, rounded to nearest.
  localparam int unsigned DIV      = (CLOCK_RATE + BAUD_RATE / 2) / BAUD_RATE;
  localparam int unsigned BAUD_W   = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int unsigned CNT_MAX  = (DATA_WIDTH > STOP_BITS) ? DATA_WIDTH : STOP_BITS;
  localparam int unsigned BIT_W    = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  // Index of the bit that goes on the line after the current data bit.
  localparam int unsigned NEXT_IDX = (DATA_WIDTH > 1) ? 1 : 0;

  // Reject parameter sets that cannot produce a valid frame.
  generate
    if (DIV < 2) begin : g_div_check
      $error("uart_byte_tx: CLOCK_RATE/BAUD_RATE gives a divisor below 2");
    end
    if (DATA_WIDTH < 1 || DATA_WIDTH > 16) begin : g_width_check
      $error("uart_byte_tx: DATA_WIDTH must be 1..16");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_stop_check
      $error("uart_byte_tx: STOP_BITS must be 1 or 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t                r_state;
  logic [BAUD_W-1:0]     r_baud;
  logic [BIT_W-1:0]      r_bit;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_tx;
  logic                  r_ready;
  logic                  r_busy;

  logic w_accept;
  logic w_baud_end;
  logic w_last_stop;
  logic w_stop_pre;

  // Handshake and bit-boundary decodes.
  always_comb begin
    w_accept    = valid && r_ready;
    w_baud_end  = (r_baud == BAUD_W'(DIV - 1));
    w_last_stop = (r_bit == BIT_W'(STOP_BITS - 1));
    w_stop_pre  = (r_state == S_STOP) && w_last_stop && (r_baud == BAUD_W'(DIV - 2));
  end

  // Frame FSM with registered line and handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_baud <= '0;
          r_bit  <= '0;
          if (w_accept) begin
            r_shift <= data;
            r_state <= S_START;
            r_tx    <= 1'b0;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
          end
        end

        S_START: begin
          if (w_baud_end) begin
            r_baud  <= '0;
            r_state <= S_DATA;
            r_tx    <= r_shift[0];
          end else begin
            r_baud <= r_baud + BAUD_W'(1);
          end
        end

        S_DATA: begin
          if (w_baud_end) begin
            r_baud  <= '0;
            r_shift <= r_shift >> 1;
            if (r_bit == BIT_W'(DATA_WIDTH - 1)) begin
              r_bit   <= '0;
              r_state <= S_STOP;
              r_tx    <= 1'b1;
            end else begin
              r_bit <= r_bit + BIT_W'(1);
              r_tx  <= r_shift[NEXT_IDX];
            end
          end else begin
            r_baud <= r_baud + BAUD_W'(1);
          end
        end

        S_STOP: begin
          // Open the handshake for exactly the final stop cycle.
          if (w_stop_pre) begin
            r_ready <= 1'b1;
          end
          if (w_baud_end) begin
            r_baud <= '0;
            if (w_last_stop) begin
              r_bit <= '0;
              if (w_accept) begin
                r_shift <= data;
                r_state <= S_START;
                r_tx    <= 1'b0;
                r_ready <= 1'b0;
              end else begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
              end
            end else begin
              r_bit <= r_bit + BIT_W'(1);
            end
          end else begin
            r_baud <= r_baud + BAUD_W'(1);
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_tx    <= 1'b1;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign tx    = r_tx;
  assign ready = r_ready;
  assign busy  = r_busy;

endmodule

// File: tb/tb_uart_byte_tx.sv
// Directed bench for uart_byte_tx: framing, handshake, back-to-back, reset abort, 2-stop loopback.
module tb_uart_byte_tx;

  logic       clk;
  logic       rst;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic       tx;
  logic       busy;
  logic [7:0] data2;
  logic       valid2;
  logic       ready2;
  logic       tx2;
  logic       busy2;

  int errors;
  int checks;

  uart_byte_tx #(
    .CLOCK_RATE(100_000),
    .BAUD_RATE (9600),
    .DATA_WIDTH(8),
    .STOP_BITS (1)
  ) u_dut (
    .clk  (clk),
    .rst  (rst),
    .data (data),
    .valid(valid),
    .ready(ready),
    .tx   (tx),
    .busy (busy)
  );

  uart_byte_tx #(
    .CLOCK_RATE(100_000),
    .BAUD_RATE (9600),
    .DATA_WIDTH(8),
    .STOP_BITS (2)
  ) u_dut2 (
    .clk  (clk),
    .rst  (rst),
    .data (data2),
    .valid(valid2),
    .ready(ready2),
    .tx   (tx2),
    .busy (busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present a word and wait (bounded) for the accepting edge; returns just after that edge.
  task automatic do_accept(input logic [7:0] b, input int sb, input bit hold);
    bit found;
    found = 1'b0;
    if (sb == 2) begin
      data2 = b; valid2 = 1'b1;
    end else begin
      data = b; valid = 1'b1;
    end
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (((sb == 2) ? ready2 : ready) === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: ready stayed %b, required 1 within 500 cycles",
               (sb == 2) ? ready2 : ready);
    end
    @(posedge clk);
    #1;
    if (!hold) begin
      if (sb == 2) valid2 = 1'b0;
      else valid = 1'b0;
    end
  endtask

  // Sample one whole frame starting with the first start cycle; checks line, decode, handshake.
  task automatic expect_frame(input logic [7:0] b, input int sb, input string name);
    int   len;
    int   idx;
    int   bad_line;
    int   bad_hs;
    int   first_line;
    int   first_hs;
    logic exp_bit;
    logic t;
    logic r;
    logic bz;
    logic [7:0] got;
    len        = (1 + 8 + sb) * 10;
    bad_line   = 0;
    bad_hs     = 0;
    first_line = -1;
    first_hs   = -1;
    got        = 8'h00;
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      t  = (sb == 2) ? tx2 : tx;
      r  = (sb == 2) ? ready2 : ready;
      bz = (sb == 2) ? busy2 : busy;
      idx = k / 10;
      if (idx == 0) exp_bit = 1'b0;
      else if (idx <= 8) exp_bit = b[idx-1];
      else exp_bit = 1'b1;
      if (t !== exp_bit) begin
        bad_line++;
        if (first_line < 0) first_line = k;
      end
      if (idx >= 1 && idx <= 8 && (k % 10) == 5) got[idx-1] = t;
      if (bz !== 1'b1 || r !== (k == len - 1)) begin
        bad_hs++;
        if (first_hs < 0) first_hs = k;
      end
    end
    checks++;
    if (bad_line != 0) begin
      errors++;
      $display("FAIL %s_line: %0d bad tx cycles (first at cycle %0d), required 0", name, bad_line, first_line);
    end
    checks++;
    if (got !== b) begin
      errors++;
      $display("FAIL %s_decode: got 0x%02h, required 0x%02h", name, got, b);
    end
    checks++;
    if (bad_hs != 0) begin
      errors++;
      $display("FAIL %s_handshake: %0d bad busy/ready cycles (first at cycle %0d), required 0", name, bad_hs, first_hs);
    end
  endtask

  // Check the idle-line output triple of the 1-stop instance.
  task automatic check_idle(input string name);
    checks++;
    if ({tx, ready, busy} !== 3'b110) begin
      errors++;
      $display("FAIL %s: tx/ready/busy=%b%b%b, required 110", name, tx, ready, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset_held");
    checks++;
    if ({tx2, ready2, busy2} !== 3'b110) begin
      errors++;
      $display("FAIL reset_held2: tx/ready/busy=%b%b%b, required 110", tx2, ready2, busy2);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_idle("reset_release");
  endtask

  task automatic test_single();
    do_accept(8'h55, 1, 1'b0);
    expect_frame(8'h55, 1, "single55");
    @(negedge clk);
    check_idle("single_idle_after");
  endtask

  task automatic test_back_to_back();
    do_accept(8'h00, 1, 1'b1);
    data = 8'hFF;
    expect_frame(8'h00, 1, "b2b_first");
    @(posedge clk);
    #1;
    valid = 1'b0;
    expect_frame(8'hFF, 1, "b2b_second");
    @(negedge clk);
    check_idle("b2b_idle_after");
  endtask

  task automatic test_hold_data();
    do_accept(8'hC3, 1, 1'b0);
    data = 8'h18;
    fork
      expect_frame(8'hC3, 1, "hold_data");
      begin
        repeat (40) @(posedge clk);
        #1;
        data = 8'hE7;
      end
    join
    @(negedge clk);
  endtask

  task automatic test_reset_midframe();
    do_accept(8'hA5, 1, 1'b0);
    repeat (45) @(negedge clk);
    checks++;
    if ({tx, busy} !== 2'b01) begin
      errors++;
      $display("FAIL midframe_bit3: tx/busy=%b%b, required 01", tx, busy);
    end
    #2;
    rst = 1'b1;
    #1;
    check_idle("async_reset_abort");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_idle("abort_released");
    do_accept(8'h3C, 1, 1'b0);
    expect_frame(8'h3C, 1, "after_abort");
  endtask

  task automatic test_loopback_two_stop();
    string msg;
    msg = "Hello World! ";
    for (int i = 0; i < msg.len(); i++) begin
      do_accept(msg[i], 2, 1'b0);
      expect_frame(msg[i], 2, "loop2");
    end
    @(negedge clk);
    checks++;
    if ({tx2, ready2, busy2} !== 3'b110) begin
      errors++;
      $display("FAIL loop2_idle_after: tx/ready/busy=%b%b%b, required 110", tx2, ready2, busy2);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b1;
    data   = 8'h00;
    valid  = 1'b0;
    data2  = 8'h00;
    valid2 = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_hold_data();
    test_reset_midframe();
    test_loopback_two_stop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
